irq_pend_8: RTL and testbench
=============================

IRQ_PEND_8 -- requirements
Module: irq_pend_8

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops per request line (legal range 2..3).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 req_i  input  8  asynchronous request lines; a rising edge is one event.
REQ-005 mask  input  8  synchronous enable per line; 1 = line may be presented downstream.
REQ-006 ack  input  1  downstream has served the line named by ack_idx this cycle.
REQ-007 ack_idx  input  3  index (0..7) of the served line, normally the 8:3 priority-encoder result.
REQ-008 ovf_clr  input  1  clear all sticky overflow flags.
REQ-009 pend  output  8  pending AND mask; feeds the downstream 8:3 priority encoder (bit 7 highest).
REQ-010 irq  output  1  OR-reduction of pend.
REQ-011 ovf  output  8  sticky per-line overflow flags.

Function
REQ-012 Each line SHALL pass through SYNC_STAGES flops, then a one-flop delayed copy; event = synced AND NOT delayed.
REQ-013 A req_i high first sampled at edge k SHALL set pending[i] at edge k+SYNC_STAGES (pend visible after 3 edges at default).
REQ-014 Level-high with no new rising edge SHALL NOT re-set pending after it is cleared.
REQ-015 ack=1 SHALL clear pending[ack_idx] at the same rising edge; ack on a non-pending bit SHALL have no effect.
REQ-016 Event and ack on the same bit in the same cycle: pending SHALL remain 1 (new event wins); ovf unchanged.
REQ-017 Event on a bit already pending and not acked that cycle SHALL set ovf[i]; pending stays 1 (events do not queue).
REQ-018 ovf_clr=1 SHALL clear all ovf bits at that edge; an overflow event in the same cycle SHALL leave its bit set.
REQ-019 mask SHALL gate only pend/irq; masked lines still capture events, and unmasking exposes them with zero latency.
REQ-020 pend and irq SHALL be combinational from registered pending and mask input; no added latency.
REQ-021 Multiple simultaneous events on different lines SHALL all be captured in the same cycle.
REQ-022 ack_idx SHALL be ignored when ack=0.

Reset
REQ-023 rst_n low SHALL asynchronously clear all synchronizer flops, delayed copies, pending and ovf; pend=0, irq=0, ovf=0.
REQ-024 A line held high across reset release SHALL register exactly one event (delayed copy resets to 0).
REQ-025 Reset asserted mid-operation SHALL discard all pending events and overflow history.

Structure
REQ-026 A shared package SHALL hold NUM_LINES=8, IDX_W=3 and the default SYNC_STAGES constant.
REQ-027 One sub-module sync_edge (synchronizer chain + edge detector, single bit) SHALL be instantiated NUM_LINES times.
REQ-028 Pending/ovf register update SHALL live in the top module; total RTL 120-400 lines.

Verification
REQ-029 Reset, pulse req_i=8'h08 for 1 cycle, mask=8'hFF -> pend=8'h08, irq=1 after 3 edges; ack=1, ack_idx=3 -> pend=8'h00, irq=0 next cycle.
REQ-030 req_i rises on lines 7 and 0 together, mask=8'hFF -> pend=8'h81; ack idx 7 -> pend=8'h01; ack idx 0 -> pend=8'h00.
REQ-031 mask=8'hFE, event on line 0 -> pend=0, irq=0; set mask=8'hFF -> pend=8'h01 same cycle.
REQ-032 Second rising edge on line 2 while pending -> ovf=8'h04, pend bit stays 1; ovf_clr -> ovf=8'h00.
REQ-033 Event on line 5 reaches pending logic in same cycle as ack idx 5 -> pend[5]=1, ovf[5]=0.
REQ-034 Assert rst_n=0 with pend=8'hF0 and ovf=8'h10 mid-cycle -> all outputs 0 immediately; line held high at release -> one event, pend bit set after 3 edges.

Source files
------------

// File: rtl/irq_pend_8_pkg.sv
// Shared constants for the 8-line pending-interrupt collector.
package irq_pend_8_pkg;
  localparam int unsigned NUM_LINES       = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/irq_pend_8_sync_edge.sv
// Single-bit synchronizer chain followed by a rising-edge detector.
module sync_edge
  import irq_pend_8_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Delayed copy resets low so a line held high through reset gives one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/irq_pend_8.sv
// Captures rising edges on 8 async request lines as pending bits with ack and sticky overflow.
module irq_pend_8
  import irq_pend_8_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] req_i,
  input  logic [NUM_LINES-1:0] mask,
  input  logic                 ack,
  input  logic [IDX_W-1:0]     ack_idx,
  input  logic                 ovf_clr,
  output logic [NUM_LINES-1:0] pend,
  output logic                 irq,
  output logic [NUM_LINES-1:0] ovf
);

  logic [NUM_LINES-1:0] evt;
  logic [NUM_LINES-1:0] ack_vec;
  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic [NUM_LINES-1:0] ovf_q, ovf_d;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .req_i(req_i[i]),
      .evt_o(evt[i])
    );
  end

  // A new event beats a same-cycle ack; overflow only when pending and not acked.
  always_comb begin
    ack_vec = '0;
    if (ack) ack_vec[ack_idx] = 1'b1;
    pending_d = (pending_q & ~ack_vec) | evt;
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (evt & pending_q & ~ack_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pend = pending_q & mask;
  assign irq  = |pend;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_irq_pend_8.sv
// Directed vector bench for irq_pend_8 (default SYNC_STAGES = 2).
module tb_irq_pend_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic       ovf_clr;
  logic [7:0] pend;
  logic       irq;
  logic [7:0] ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       ack;
    logic [2:0] idx;
    logic       clr;
    logic [7:0] e_pend;
    logic       e_irq;
    logic [7:0] e_ovf;
    string      name;
  } vec_t;

  vec_t tv[$];

  irq_pend_8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .mask   (mask),
    .ack    (ack),
    .ack_idx(ack_idx),
    .ovf_clr(ovf_clr),
    .pend   (pend),
    .irq    (irq),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [7:0] r, input logic [7:0] m, input logic a,
                              input logic [2:0] i, input logic c, input logic [7:0] ep,
                              input logic [7:0] eo, input string nm);
    vec_t v;
    v.req = r; v.msk = m; v.ack = a; v.idx = i; v.clr = c;
    v.e_pend = ep; v.e_irq = (ep != 8'h00); v.e_ovf = eo; v.name = nm;
    tv.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [7:0] ep, input logic ei, input logic [7:0] eo);
    n_vec++;
    if (pend !== ep || irq !== ei || ovf !== eo) begin
      n_err++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h, expected pend=%h irq=%b ovf=%h",
               nm, pend, irq, ovf, ep, ei, eo);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = 8'h00; mask = 8'hFF; ack = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;
  endtask

  initial begin
    // Each row: inputs held across one rising edge, outputs checked 1 time unit later.
    add(8'h08, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "p3_edge1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "p3_edge2");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h08, 8'h00, "p3_edge3");
    add(8'h00, 8'hFF, 1, 3, 0, 8'h00, 8'h00, "ack3");
    add(8'h81, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l70_e1");
    add(8'h81, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l70_e2");
    add(8'h81, 8'hFF, 0, 0, 0, 8'h81, 8'h00, "l70_e3");
    add(8'h81, 8'hFF, 1, 7, 0, 8'h01, 8'h00, "ack7");
    add(8'h81, 8'hFF, 1, 0, 0, 8'h00, 8'h00, "ack0");
    add(8'h81, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "level_no_reset");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "fall1");
    add(8'h00, 8'hFE, 0, 0, 0, 8'h00, 8'h00, "fall2");
    add(8'h01, 8'hFE, 0, 0, 0, 8'h00, 8'h00, "msk_e1");
    add(8'h00, 8'hFE, 0, 0, 0, 8'h00, 8'h00, "msk_e2");
    add(8'h00, 8'hFE, 0, 0, 0, 8'h00, 8'h00, "msk_hidden");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h01, 8'h00, "unmask_idx_ignored");
    add(8'h00, 8'hFF, 1, 0, 0, 8'h00, 8'h00, "ack0_b");
    add(8'h04, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l2_e1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l2_e2");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h04, 8'h00, "l2_e3");
    add(8'h04, 8'hFF, 0, 0, 0, 8'h04, 8'h00, "l2_again1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h04, 8'h00, "l2_again2");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h04, 8'h04, "l2_ovf");
    add(8'h00, 8'hFF, 0, 0, 1, 8'h04, 8'h00, "ovf_clr");
    add(8'h00, 8'hFF, 1, 2, 0, 8'h00, 8'h00, "ack2");
    add(8'h00, 8'hFF, 1, 6, 0, 8'h00, 8'h00, "ack_nonpending");
    add(8'h20, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l5_e1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l5_e2");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h20, 8'h00, "l5_e3");
    add(8'h20, 8'hFF, 0, 0, 0, 8'h20, 8'h00, "l5_again1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h20, 8'h00, "l5_again2");
    add(8'h00, 8'hFF, 1, 5, 0, 8'h20, 8'h00, "l5_evt_vs_ack");
    add(8'h00, 8'hFF, 1, 5, 0, 8'h00, 8'h00, "ack5");
    add(8'h02, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l1_e1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h00, 8'h00, "l1_e2");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h02, 8'h00, "l1_e3");
    add(8'h02, 8'hFF, 0, 0, 0, 8'h02, 8'h00, "l1_again1");
    add(8'h00, 8'hFF, 0, 0, 0, 8'h02, 8'h00, "l1_again2");
    add(8'h00, 8'hFF, 0, 0, 1, 8'h02, 8'h02, "ovf_vs_clr");
    add(8'h00, 8'hFF, 0, 0, 1, 8'h02, 8'h00, "ovf_clr_b");
    add(8'h00, 8'hFF, 1, 1, 0, 8'h00, 8'h00, "ack1");

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_state", 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 8'h00, 1'b0, 8'h00);

    foreach (tv[k]) begin
      req_i = tv[k].req; mask = tv[k].msk; ack = tv[k].ack;
      ack_idx = tv[k].idx; ovf_clr = tv[k].clr;
      tick();
      check(tv[k].name, tv[k].e_pend, tv[k].e_irq, tv[k].e_ovf);
    end
    idle_inputs();

    // Build pend=F0, ovf=10, then check mask gating is purely combinational.
    req_i = 8'hF0; tick();
    req_i = 8'h00; tick(); tick();
    check("seq_pend_f0", 8'hF0, 1'b1, 8'h00);
    req_i = 8'h10; tick();
    req_i = 8'h00; tick(); tick();
    check("seq_ovf_10", 8'hF0, 1'b1, 8'h10);
    mask = 8'h00; #1;
    check("seq_mask_all", 8'h00, 1'b0, 8'h10);
    mask = 8'h30; #1;
    check("seq_mask_30", 8'h30, 1'b1, 8'h10);
    mask = 8'hFF; #1;

    // Mid-cycle async reset with line 3 held high through release.
    req_i = 8'h08;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check("seq_async_rst", 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("seq_rel_e1", 8'h00, 1'b0, 8'h00);
    tick();
    check("seq_rel_e2", 8'h00, 1'b0, 8'h00);
    tick();
    check("seq_rel_e3", 8'h08, 1'b1, 8'h00);
    ack = 1'b1; ack_idx = 3'd3; tick();
    ack = 1'b0;
    check("seq_rel_ack", 8'h00, 1'b0, 8'h00);
    tick(); tick(); tick();
    check("seq_rel_single", 8'h00, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
